// File: rtl/touch_pkg.sv
// rtl/touch_pkg.sv - shared constants for the touch gesture controller
//
// Purpose: FSM state encoding, zoom gesture pattern and default swipe codes
//          shared by touch_gesture_ctrl and its sub-modules.
// Ports:   none (package).
package touch_pkg;

  // FSM state encoding, kept as plain constants for legacy tools.
  typedef logic [1:0] touch_state_t;
  localparam touch_state_t ST_IDLE   = 2'd0;
  localparam touch_state_t ST_TOUCH  = 2'd1;
  localparam touch_state_t ST_COMMIT = 2'd2;

  // Zoom gestures carry this pattern in bits [6:3]; bit 0 gives direction.
  localparam logic [3:0] ZOOM_CODE = 4'b1001;

  localparam logic [7:0] GEST_NEXT_DEF = 8'h18;
  localparam logic [7:0] GEST_PREV_DEF = 8'h10;

  function automatic logic is_zoom(input logic [7:0] gesture);
    return gesture[6:3] == ZOOM_CODE;
  endfunction

endpackage

// File: rtl/page_addr_gen.sv
// rtl/page_addr_gen.sv - frame-buffer page index and base-address accumulator
//
// Purpose: holds the current page index, applies next/prev requests with
//          end-of-range refusal (or wrap when TOUCH_PAGE_WRAP_EN is defined),
//          pulses page_change after a move and tracks the page base address
//          by adding/subtracting one frame size.
// Ports:   iCLK, iRSTN (async, active-low)
//          inc_req, dec_req   : move requests (single-cycle)
//          page_index         : current page
//          rd_addr            : page base address, follows page_index by 1 cycle
//          page_change        : one-cycle pulse after the index moved
// Macro:   TOUCH_PAGE_WRAP_EN
module page_addr_gen #(
  parameter int H_RES      = 800,
  parameter int V_RES      = 480,
  parameter int NUM_PAGES  = 3,
  parameter int RESET_PAGE = 1,
  parameter int AW         = 23,
  localparam int PW        = $clog2(NUM_PAGES)
) (
  input  logic          iCLK,
  input  logic          iRSTN,
  input  logic          inc_req,
  input  logic          dec_req,
  output logic [PW-1:0] page_index,
  output logic [AW-1:0] rd_addr,
  output logic          page_change
);

  localparam logic [AW-1:0] FRAME      = AW'(H_RES * V_RES);
  localparam logic [AW-1:0] RESET_BASE = AW'(RESET_PAGE * H_RES * V_RES);
  localparam logic [PW-1:0] LAST_IDX   = PW'(NUM_PAGES - 1);
  localparam logic [PW-1:0] RESET_IDX  = PW'(RESET_PAGE);

  // Direction of the last move, used by the address step one cycle later.
  logic up_q;
`ifdef TOUCH_PAGE_WRAP_EN
  localparam logic [AW-1:0] LAST_BASE = AW'((NUM_PAGES - 1) * H_RES * V_RES);
  logic wrap_q;
`endif

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      page_index  <= RESET_IDX;
      page_change <= 1'b0;
      up_q        <= 1'b0;
`ifdef TOUCH_PAGE_WRAP_EN
      wrap_q      <= 1'b0;
`endif
    end else begin
      page_change <= 1'b0;
`ifdef TOUCH_PAGE_WRAP_EN
      wrap_q      <= 1'b0;
`endif
      if (inc_req) begin
        if (page_index < LAST_IDX) begin
          page_index  <= page_index + PW'(1);
          page_change <= 1'b1;
          up_q        <= 1'b1;
        end
`ifdef TOUCH_PAGE_WRAP_EN
        else begin
          page_index  <= '0;
          page_change <= 1'b1;
          up_q        <= 1'b1;
          wrap_q      <= 1'b1;
        end
`endif
      end else if (dec_req) begin
        if (page_index > '0) begin
          page_index  <= page_index - PW'(1);
          page_change <= 1'b1;
          up_q        <= 1'b0;
        end
`ifdef TOUCH_PAGE_WRAP_EN
        else begin
          page_index  <= LAST_IDX;
          page_change <= 1'b1;
          up_q        <= 1'b0;
          wrap_q      <= 1'b1;
        end
`endif
      end
    end
  end

  // Address steps by one frame per move, so no multiplier is needed.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      rd_addr <= RESET_BASE;
    end else if (page_change) begin
`ifdef TOUCH_PAGE_WRAP_EN
      if (wrap_q)
        rd_addr <= up_q ? '0 : LAST_BASE;
      else
`endif
        rd_addr <= up_q ? rd_addr + FRAME : rd_addr - FRAME;
    end
  end

endmodule

// File: rtl/touch_gesture_ctrl.sv
// rtl/touch_gesture_ctrl.sv - touch gesture decoder driving page flip and zoom
//
// Purpose: synchronises the touch controller ready strobe, tracks a touch
//          session (IDLE/TOUCH/COMMIT), latches swipe/zoom gestures and
//          commits them as a page move or a zoom-complete pulse.
// Ports:   iCLK, iRSTN (async, active-low), iREADY (async strobe)
//          iREG_X1/X2, iREG_Y1/Y2, iREG_TOUCH_COUNT, iREG_GESTURE : touch regs
//          oPAGE_INDEX, oRD_ADDR, oPAGE_CHANGE : page selection
//          oZOOM_VALID, oZOOM_OUT, o{X,Y}{1,2}_{START,END} : zoom result
// Macro:   TOUCH_PAGE_WRAP_EN (page wrap at the ends, in page_addr_gen)
module touch_gesture_ctrl
  import touch_pkg::*;
#(
  parameter int         H_RES      = 800,
  parameter int         V_RES      = 480,
  parameter int         NUM_PAGES  = 3,
  parameter int         RESET_PAGE = 1,
  parameter int         TIMEOUT_W  = 9,
  parameter logic [7:0] GEST_NEXT  = GEST_NEXT_DEF,
  parameter logic [7:0] GEST_PREV  = GEST_PREV_DEF,
  parameter int         AW         = 23,
  localparam int        XW         = $clog2(H_RES),
  localparam int        YW         = $clog2(V_RES),
  localparam int        PW         = $clog2(NUM_PAGES)
) (
  input  logic          iCLK,
  input  logic          iRSTN,
  input  logic          iREADY,
  input  logic [XW-1:0] iREG_X1,
  input  logic [XW-1:0] iREG_X2,
  input  logic [YW-1:0] iREG_Y1,
  input  logic [YW-1:0] iREG_Y2,
  input  logic [1:0]    iREG_TOUCH_COUNT,
  input  logic [7:0]    iREG_GESTURE,
  output logic [PW-1:0] oPAGE_INDEX,
  output logic [AW-1:0] oRD_ADDR,
  output logic          oPAGE_CHANGE,
  output logic          oZOOM_VALID,
  output logic          oZOOM_OUT,
  output logic [XW-1:0] oX1_START,
  output logic [XW-1:0] oX2_START,
  output logic [XW-1:0] oX1_END,
  output logic [XW-1:0] oX2_END,
  output logic [YW-1:0] oY1_START,
  output logic [YW-1:0] oY2_START,
  output logic [YW-1:0] oY1_END,
  output logic [YW-1:0] oY2_END
);

  // Point count is not needed: gestures are decoded from the gesture code.
  wire unused_touch_count = &{1'b0, iREG_TOUCH_COUNT};

  logic [2:0]           rdy_sync;
  touch_state_t         state;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 next_q, prev_q, zoom_q, zoom_out_q;

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) rdy_sync <= '0;
    else        rdy_sync <= {rdy_sync[1:0], iREADY};
  end

  wire rdy_rise = rdy_sync[1] & ~rdy_sync[2];
  wire rdy_fall = ~rdy_sync[1] & rdy_sync[2];

  wire in_idle      = (state == ST_IDLE);
  wire in_touch     = (state == ST_TOUCH);
  wire in_commit    = (state == ST_COMMIT);
  wire gest_zoom    = is_zoom(iREG_GESTURE);
  // The rise that opens a session is decoded like any rise in TOUCH.
  wire rise_act     = rdy_rise & (in_idle | in_touch);
  wire zoom_lat     = zoom_q & in_touch;
  wire timeout      = in_touch & tmo_cnt[TIMEOUT_W-1];
  wire zoom_release = in_touch & rdy_rise & zoom_q & (iREG_GESTURE == 8'h00);

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rdy_rise) begin
            state   <= ST_TOUCH;
            tmo_cnt <= '0;
          end
        end
        ST_TOUCH: begin
          if (timeout || zoom_release) state <= ST_COMMIT;
          // Each finger lift restarts the session timeout.
          if (rdy_fall) tmo_cnt <= '0;
          else          tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
        end
        ST_COMMIT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      next_q     <= 1'b0;
      prev_q     <= 1'b0;
      zoom_q     <= 1'b0;
      zoom_out_q <= 1'b0;
      oX1_START  <= '0;
      oX2_START  <= '0;
      oY1_START  <= '0;
      oY2_START  <= '0;
      oX1_END    <= '0;
      oX2_END    <= '0;
      oY1_END    <= '0;
      oY2_END    <= '0;
    end else if (rise_act) begin
      if (gest_zoom) begin
        zoom_q     <= 1'b1;
        zoom_out_q <= iREG_GESTURE[0];
      end else if (!in_touch) begin
        zoom_q     <= 1'b0;
        zoom_out_q <= 1'b0;
      end
      if (zoom_lat) begin
        if (gest_zoom) begin
          oX1_END <= iREG_X1;
          oX2_END <= iREG_X2;
          oY1_END <= iREG_Y1;
          oY2_END <= iREG_Y2;
        end
        next_q <= 1'b0;
        prev_q <= 1'b0;
      end else begin
        oX1_START <= iREG_X1;
        oX2_START <= iREG_X2;
        oY1_START <= iREG_Y1;
        oY2_START <= iREG_Y2;
        // Flags only accumulate within a session; a new session starts clean.
        next_q <= (next_q & in_touch) | (iREG_GESTURE == GEST_NEXT);
        prev_q <= (prev_q & in_touch) | (iREG_GESTURE == GEST_PREV);
      end
    end else if (in_idle) begin
      next_q     <= 1'b0;
      prev_q     <= 1'b0;
      zoom_q     <= 1'b0;
      zoom_out_q <= 1'b0;
    end
  end

  // Zoom wins over a pending swipe; next wins over prev.
  wire page_inc = in_commit & ~zoom_q & next_q;
  wire page_dec = in_commit & ~zoom_q & ~next_q & prev_q;

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      oZOOM_VALID <= 1'b0;
      oZOOM_OUT   <= 1'b0;
    end else begin
      oZOOM_VALID <= in_commit & zoom_q;
      if (in_commit && zoom_q) oZOOM_OUT <= zoom_out_q;
    end
  end

  page_addr_gen #(
    .H_RES      (H_RES),
    .V_RES      (V_RES),
    .NUM_PAGES  (NUM_PAGES),
    .RESET_PAGE (RESET_PAGE),
    .AW         (AW)
  ) u_page_addr_gen (
    .iCLK        (iCLK),
    .iRSTN       (iRSTN),
    .inc_req     (page_inc),
    .dec_req     (page_dec),
    .page_index  (oPAGE_INDEX),
    .rd_addr     (oRD_ADDR),
    .page_change (oPAGE_CHANGE)
  );

endmodule

// File: tb/tb_touch_gesture_ctrl.sv
// tb/tb_touch_gesture_ctrl.sv - directed self-checking bench for touch_gesture_ctrl
//
// Purpose: drives swipe, zoom, timeout and reset scenarios and compares the
//          page/zoom outputs against hand-computed values.
// Ports:   none (top-level bench).
// Macro:   TOUCH_PAGE_WRAP_EN selects the wrap-build expected values.
module tb_touch_gesture_ctrl;

  logic        iCLK = 1'b0;
  logic        iRSTN = 1'b0;
  logic        iREADY = 1'b0;
  logic [9:0]  iREG_X1 = '0, iREG_X2 = '0;
  logic [8:0]  iREG_Y1 = '0, iREG_Y2 = '0;
  logic [1:0]  iREG_TOUCH_COUNT = '0;
  logic [7:0]  iREG_GESTURE = '0;
  logic [1:0]  oPAGE_INDEX;
  logic [22:0] oRD_ADDR;
  logic        oPAGE_CHANGE, oZOOM_VALID, oZOOM_OUT;
  logic [9:0]  oX1_START, oX2_START, oX1_END, oX2_END;
  logic [8:0]  oY1_START, oY2_START, oY1_END, oY2_END;

  // 800*480 = 0x5DC00 per page.
  localparam logic [22:0] BASE0 = 23'h000000;
  localparam logic [22:0] BASE1 = 23'h05DC00;
  localparam logic [22:0] BASE2 = 23'h0BB800;

  int n_checks = 0;
  int n_pass   = 0;
  int pc_cnt   = 0;
  int zv_cnt   = 0;
  logic zo_seen = 1'b0;

  always #5 iCLK = ~iCLK;

  touch_gesture_ctrl dut (
    .iCLK (iCLK), .iRSTN (iRSTN), .iREADY (iREADY),
    .iREG_X1 (iREG_X1), .iREG_X2 (iREG_X2),
    .iREG_Y1 (iREG_Y1), .iREG_Y2 (iREG_Y2),
    .iREG_TOUCH_COUNT (iREG_TOUCH_COUNT), .iREG_GESTURE (iREG_GESTURE),
    .oPAGE_INDEX (oPAGE_INDEX), .oRD_ADDR (oRD_ADDR),
    .oPAGE_CHANGE (oPAGE_CHANGE), .oZOOM_VALID (oZOOM_VALID),
    .oZOOM_OUT (oZOOM_OUT),
    .oX1_START (oX1_START), .oX2_START (oX2_START),
    .oX1_END (oX1_END), .oX2_END (oX2_END),
    .oY1_START (oY1_START), .oY2_START (oY2_START),
    .oY1_END (oY1_END), .oY2_END (oY2_END)
  );

  always @(negedge iCLK) begin
    if (oPAGE_CHANGE) pc_cnt++;
    if (oZOOM_VALID) begin
      zv_cnt++;
      zo_seen = oZOOM_OUT;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge iCLK);
  endtask

  task automatic do_reset();
    @(negedge iCLK);
    iRSTN  = 1'b0;
    iREADY = 1'b0;
    cycles(3);
    iRSTN = 1'b1;
    cycles(2);
  endtask

  task automatic set_regs(input logic [7:0] g, input logic [9:0] x1, input logic [8:0] y1,
                          input logic [9:0] x2, input logic [8:0] y2);
    iREG_GESTURE = g;
    iREG_X1 = x1; iREG_Y1 = y1;
    iREG_X2 = x2; iREG_Y2 = y2;
  endtask

  task automatic touch_pulse(input logic [7:0] g, input logic [9:0] x1, input logic [8:0] y1,
                             input logic [9:0] x2, input logic [8:0] y2, input int hold);
    @(negedge iCLK);
    set_regs(g, x1, y1, x2, y2);
    iREADY = 1'b1;
    cycles(hold);
    iREADY = 1'b0;
    cycles(hold);
  endtask

  int pc_base, zv_base, n_edges;
  bit seen;

  initial begin
    // Reset state
    cycles(3);
    iRSTN = 1'b1;
    cycles(1);
    check("rst_index", 32'(oPAGE_INDEX), 32'd1);
    check("rst_addr", 32'(oRD_ADDR), 32'(BASE1));
    check("rst_pchg", 32'(oPAGE_CHANGE), 32'd0);
    check("rst_zvalid", 32'(oZOOM_VALID), 32'd0);
    check("rst_x1s", 32'(oX1_START), 32'd0);
    check("rst_y2e", 32'(oY2_END), 32'd0);

    // Swipe next 1 -> 2
    pc_base = pc_cnt;
    touch_pulse(8'h18, 10'd10, 9'd10, 10'd0, 9'd0, 4);
    cycles(300);
    check("next_index", 32'(oPAGE_INDEX), 32'd2);
    check("next_addr", 32'(oRD_ADDR), 32'(BASE2));
    check("next_pulses", 32'(pc_cnt - pc_base), 32'd1);

    // Next at the last page: refused, or wraps to page 0
    pc_base = pc_cnt;
    touch_pulse(8'h18, 10'd10, 9'd10, 10'd0, 9'd0, 4);
    cycles(300);
`ifdef TOUCH_PAGE_WRAP_EN
    check("top_index", 32'(oPAGE_INDEX), 32'd0);
    check("top_addr", 32'(oRD_ADDR), 32'(BASE0));
    check("top_pulses", 32'(pc_cnt - pc_base), 32'd1);
`else
    check("top_index", 32'(oPAGE_INDEX), 32'd2);
    check("top_addr", 32'(oRD_ADDR), 32'(BASE2));
    check("top_pulses", 32'(pc_cnt - pc_base), 32'd0);
`endif

    // Swipe prev 1 -> 0
    do_reset();
    pc_base = pc_cnt;
    touch_pulse(8'h10, 10'd5, 9'd5, 10'd0, 9'd0, 4);
    cycles(300);
    check("prev_index", 32'(oPAGE_INDEX), 32'd0);
    check("prev_addr", 32'(oRD_ADDR), 32'(BASE0));
    check("prev_pulses", 32'(pc_cnt - pc_base), 32'd1);

    // Prev at page 0: refused, or wraps to the last page
    pc_base = pc_cnt;
    touch_pulse(8'h10, 10'd5, 9'd5, 10'd0, 9'd0, 4);
    cycles(300);
`ifdef TOUCH_PAGE_WRAP_EN
    check("bot_index", 32'(oPAGE_INDEX), 32'd2);
    check("bot_addr", 32'(oRD_ADDR), 32'(BASE2));
    check("bot_pulses", 32'(pc_cnt - pc_base), 32'd1);
`else
    check("bot_index", 32'(oPAGE_INDEX), 32'd0);
    check("bot_addr", 32'(oRD_ADDR), 32'(BASE0));
    check("bot_pulses", 32'(pc_cnt - pc_base), 32'd0);
`endif

    // Zoom out: start, end, release
    do_reset();
    pc_base = pc_cnt;
    zv_base = zv_cnt;
    touch_pulse(8'h49, 10'd100, 9'd50, 10'd300, 9'd200, 5);
    touch_pulse(8'h49, 10'd80, 9'd40, 10'd400, 9'd300, 5);
    touch_pulse(8'h00, 10'd0, 9'd0, 10'd0, 9'd0, 5);
    cycles(20);
    check("zoom_pulses", 32'(zv_cnt - zv_base), 32'd1);
    check("zoom_out", 32'(zo_seen), 32'd1);
    check("zoom_x1s", 32'(oX1_START), 32'd100);
    check("zoom_y1s", 32'(oY1_START), 32'd50);
    check("zoom_x2s", 32'(oX2_START), 32'd300);
    check("zoom_y2s", 32'(oY2_START), 32'd200);
    check("zoom_x1e", 32'(oX1_END), 32'd80);
    check("zoom_y1e", 32'(oY1_END), 32'd40);
    check("zoom_x2e", 32'(oX2_END), 32'd400);
    check("zoom_y2e", 32'(oY2_END), 32'd300);
    check("zoom_index", 32'(oPAGE_INDEX), 32'd1);
    check("zoom_pchg", 32'(pc_cnt - pc_base), 32'd0);

    // Zoom in after a pending next: zoom takes priority, page unchanged
    do_reset();
    pc_base = pc_cnt;
    zv_base = zv_cnt;
    touch_pulse(8'h18, 10'd1, 9'd1, 10'd2, 9'd2, 5);
    touch_pulse(8'h48, 10'd3, 9'd3, 10'd4, 9'd4, 5);
    touch_pulse(8'h00, 10'd0, 9'd0, 10'd0, 9'd0, 5);
    cycles(20);
    check("prio_zpulses", 32'(zv_cnt - zv_base), 32'd1);
    check("prio_zout", 32'(zo_seen), 32'd0);
    check("prio_pchg", 32'(pc_cnt - pc_base), 32'd0);
    check("prio_index", 32'(oPAGE_INDEX), 32'd1);

    // Timeout restart: a lift every 100 cycles keeps the session open
    do_reset();
    pc_base = pc_cnt;
    @(negedge iCLK);
    set_regs(8'h18, 10'd7, 9'd7, 10'd0, 9'd0);
    iREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycles(50);
      iREADY = 1'b0;
      if (i < 3) begin
        cycles(50);
        iREADY = 1'b1;
      end
    end
    check("tmo_held", 32'(pc_cnt - pc_base), 32'd0);
    // From the final drive: 3 edges to the counter clear, 257 to COMMIT,
    // 1 more for the index update and page-change pulse.
    n_edges = 0;
    seen = 1'b0;
    while (!seen && n_edges < 400) begin
      @(posedge iCLK);
      n_edges++;
      @(negedge iCLK);
      if (oPAGE_CHANGE) seen = 1'b1;
    end
    check("tmo_latency", 32'(n_edges), 32'd261);
    check("tmo_index", 32'(oPAGE_INDEX), 32'd2);

    // Reset during TOUCH with next latched: gesture abandoned
    do_reset();
    touch_pulse(8'h18, 10'd9, 9'd9, 10'd0, 9'd0, 4);
    cycles(50);
    pc_base = pc_cnt;
    do_reset();
    cycles(400);
    check("mid_rst_pchg", 32'(pc_cnt - pc_base), 32'd0);
    check("mid_rst_index", 32'(oPAGE_INDEX), 32'd1);
    check("mid_rst_addr", 32'(oRD_ADDR), 32'(BASE1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/touch_gesture_ctrl.md
TOUCH_GESTURE_CTRL -- requirements
Module: touch_gesture_ctrl

Interface
REQ-001 SHALL have parameter H_RES, default 800, horizontal panel pixels.
REQ-002 SHALL have parameter V_RES, default 480, vertical panel pixels.
REQ-003 SHALL have parameter NUM_PAGES, default 3, frame-buffer pages (2..16).
REQ-004 SHALL have parameter RESET_PAGE, default 1, page index after reset (< NUM_PAGES).
REQ-005 SHALL have parameter TIMEOUT_W, default 9, touch-timeout counter width; timeout when bit TIMEOUT_W-1 sets.
REQ-006 SHALL have parameters GEST_NEXT and GEST_PREV, defaults 8'h18 and 8'h10, swipe gesture codes.
REQ-007 SHALL have parameter AW, default 23, read-address width.
REQ-008 SHALL have the following ports; XW = clog2(H_RES), YW = clog2(V_RES).
- iCLK  in  1  clock.
- iRSTN  in  1  reset; asynchronous, active-low.
- iREADY  in  1  touch-controller data-ready, asynchronous to iCLK.
- iREG_X1, iREG_X2  in  XW  touch-point X.
- iREG_Y1, iREG_Y2  in  YW  touch-point Y.
- iREG_TOUCH_COUNT  in  2  active points.
- iREG_GESTURE  in  8  gesture code.
- oPAGE_INDEX  out  clog2(NUM_PAGES)  current page.
- oRD_ADDR  out  AW  page base address = oPAGE_INDEX*H_RES*V_RES.
- oPAGE_CHANGE  out  1  one-cycle pulse on page change; resets downstream scaler.
- oZOOM_VALID  out  1  one-cycle pulse, zoom gesture complete.
- oZOOM_OUT  out  1  zoom direction (1 = out), valid with oZOOM_VALID.
- oX1_START, oX2_START, oX1_END, oX2_END  out  XW  zoom coordinates.
- oY1_START, oY2_START, oY1_END, oY2_END  out  YW  zoom coordinates.

Function
REQ-009 SHALL synchronise iREADY through 3 flops; rdy_rise = stage2 low and stage1 high; rdy_fall = the inverse.
REQ-010 SHALL implement FSM IDLE, TOUCH, COMMIT.
- IDLE -> TOUCH on rdy_rise.
- TOUCH -> COMMIT on timeout or zoom release.
- COMMIT -> IDLE unconditionally after 1 cycle.
REQ-011 SHALL clear the timeout counter on IDLE->TOUCH and on rdy_fall in TOUCH, and increment it on every other TOUCH cycle.
REQ-012 SHALL define zoom release as rdy_rise in TOUCH with iREG_GESTURE==0 while zoom is latched.
REQ-013 SHALL define zoom code as iREG_GESTURE[6:3]==4'b1001.
REQ-014 SHALL, on each rdy_rise in TOUCH:
- zoom code: latch zoom=1 and zoom_out=iREG_GESTURE[0].
- zoom latched: capture END coordinates only when the code is still zoom; clear next/prev.
- zoom not latched: capture START coordinates; set next on GEST_NEXT, set prev on GEST_PREV.
REQ-015 SHALL sample the coordinates captured on the IDLE->TOUCH rdy_rise as START.
REQ-016 SHALL, in COMMIT:
- zoom latched: pulse oZOOM_VALID and leave the page unchanged.
- else next and index < NUM_PAGES-1: increment index.
- else prev and index > 0: decrement index.
REQ-017 SHALL pulse oPAGE_CHANGE in the cycle after the index register changes; SHALL NOT pulse it on a refused move.
REQ-018 SHALL update oRD_ADDR one cycle after oPAGE_INDEX changes, by adding or subtracting H_RES*V_RES (no multiplier).
REQ-019 SHALL hold START/END outputs stable from oZOOM_VALID until the next zoom capture.
REQ-020 SHALL clear next, prev, zoom and zoom_out in IDLE.
REQ-021 SHALL ignore rdy_rise during COMMIT.
REQ-022 SHALL give zoom priority when next and zoom are both latched.

Reset
REQ-023 SHALL asynchronously set FSM=IDLE, counter=0, sync flops=0, next/prev/zoom/zoom_out=0, all pulses=0, coordinates=0, oPAGE_INDEX=RESET_PAGE and oRD_ADDR=RESET_PAGE*H_RES*V_RES.
REQ-024 SHALL abandon any gesture in progress on reset mid-TOUCH, with no pulse issued.

Configuration
REQ-025 SHALL, with macro TOUCH_PAGE_WRAP_EN defined, wrap next from NUM_PAGES-1 to 0 and prev from 0 to NUM_PAGES-1, pulsing oPAGE_CHANGE and loading the matching address; without it, moves beyond the ends are refused per REQ-016.

Structure
REQ-026 SHALL place the FSM state enum, the zoom code pattern and the default gesture codes in shared package touch_pkg.
REQ-027 SHALL implement the index register and address accumulator in sub-module page_addr_gen.

Verification
REQ-028 SHALL cover swipe next: reset, single touch with gesture 8'h18, wait 256 cycles -> index 1->2, oPAGE_CHANGE 1 pulse, oRD_ADDR=23'h0BB800.
REQ-029 SHALL cover the upper bound: index 2 with GEST_NEXT -> no change and no pulse without the macro; index 0 and address 0 with TOUCH_PAGE_WRAP_EN.
REQ-030 SHALL cover swipe prev: index 1 with gesture 8'h10 -> index 0, oRD_ADDR=0.
REQ-031 SHALL cover zoom: rdy pulses with gesture 8'h49 at (100,50)/(300,200), then (80,40)/(400,300), then gesture 0 -> oZOOM_VALID 1 pulse, oZOOM_OUT=1, START/END match, index unchanged.
REQ-032 SHALL cover timeout reset: rdy_fall every 100 cycles -> stays in TOUCH; after the last fall, COMMIT exactly 257 cycles later.
REQ-033 SHALL cover reset mid-TOUCH with next latched -> no oPAGE_CHANGE, index=RESET_PAGE.
